// File: rtl/udt_state_arbiter_if.sv
// ---------------------------------------------------------------------------
// udt_state_arbiter_if
//
// Request and status channels of the UDT socket state arbiter.
//
//   req_valid_i   [5:0]  one request bit per target state
//                        (bit 0..5 = LISTENING, CONNECTING, CONNECTED,
//                        CLOSING, SHUTDOWN, BROCKEN)
//   req_ready_o   [5:0]  grant, one-hot-or-zero
//   udt_state_o   [31:0] {24'b0, current state code}
//   state_valid_o        state-change notification pending
//   state_ready_i        consumer accepts the notification
//   illegal_o            one-cycle pulse on an accepted illegal request
//   illegal_cnt_o [7:0]  saturating count of illegal requests
//
// Modports:
//   slave  - the arbiter itself
//   master - requesters plus status consumer (e.g. a testbench)
// ---------------------------------------------------------------------------
interface udt_state_arbiter_if;
    logic [5:0]  req_valid_i;
    logic [5:0]  req_ready_o;
    logic [31:0] udt_state_o;
    logic        state_valid_o;
    logic        state_ready_i;
    logic        illegal_o;
    logic [7:0]  illegal_cnt_o;

    modport slave (
        input  req_valid_i,
        input  state_ready_i,
        output req_ready_o,
        output udt_state_o,
        output state_valid_o,
        output illegal_o,
        output illegal_cnt_o
    );

    modport master (
        output req_valid_i,
        output state_ready_i,
        input  req_ready_o,
        input  udt_state_o,
        input  state_valid_o,
        input  illegal_o,
        input  illegal_cnt_o
    );
endinterface

// File: rtl/udt_state_arbiter.sv
// ---------------------------------------------------------------------------
// udt_state_arbiter
//
// Single authoritative connection-state sequencer for one UDT socket.
// Arbitrates state-change requests with fixed priority
// (BROCKEN > SHUTDOWN > CLOSING > CONNECTED > CONNECTING > LISTENING),
// checks each granted request against the legal transition graph and
// publishes every legal change on a valid/ready status channel that only
// ever carries the newest state (backpressure never blocks transitions).
//
// Ports:
//   core_clk  - the only clock
//   core_rst  - synchronous, active-high reset
//   bus       - udt_state_arbiter_if.slave (request + status channels)
//
// Optional feature (macro UDT_STATE_ARB_TIMEOUT_EN):
//   when defined, the state is forced to BROCKEN after CONNECT_TIMEOUT
//   cycles spent in CONNECTING; when undefined no timeout logic exists.
// ---------------------------------------------------------------------------
module udt_state_arbiter #(
    parameter logic [7:0]  LISTENING       = 8'b0000_0001,
    parameter logic [7:0]  CONNECTING      = 8'b0000_0010,
    parameter logic [7:0]  CONNECTED       = 8'b0000_0100,
    parameter logic [7:0]  CLOSING         = 8'b0000_1000,
    parameter logic [7:0]  SHUTDOWN        = 8'b0001_0000,
    parameter logic [7:0]  BROCKEN         = 8'b0010_0000,
    parameter logic [31:0] CONNECT_TIMEOUT = 32'd1_000_000
) (
    input  logic                core_clk,
    input  logic                core_rst,
    udt_state_arbiter_if.slave  bus
);

    // Abstract state; enum index minus one equals the request bit index,
    // so a granted bit maps straight onto its target state.
    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_LISTENING  = 3'd1,
        ST_CONNECTING = 3'd2,
        ST_CONNECTED  = 3'd3,
        ST_CLOSING    = 3'd4,
        ST_SHUTDOWN   = 3'd5,
        ST_BROCKEN    = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic        state_valid_reg, state_valid_next;
    logic        illegal_reg, illegal_next;
    logic [7:0]  illegal_cnt_reg, illegal_cnt_next;

    logic        timeout_hit;
    logic        arb_en;
    logic [5:0]  grant;
    logic [2:0]  grant_idx;
    state_t      target;
    logic [7:0]  state_code;

    // -----------------------------------------------------------------------
    // Legal transition graph
    // -----------------------------------------------------------------------
    function automatic logic is_legal(input state_t cur, input state_t tgt);
        logic ok;
        ok = 1'b0;
        if (tgt == ST_BROCKEN) begin
            ok = (cur != ST_INIT) && (cur != ST_BROCKEN);
        end else begin
            unique case (cur)
                ST_INIT:       ok = (tgt == ST_LISTENING) || (tgt == ST_CONNECTING);
                ST_LISTENING:  ok = (tgt == ST_CONNECTING);
                ST_CONNECTING: ok = (tgt == ST_CONNECTED);
                ST_CONNECTED:  ok = (tgt == ST_CLOSING) || (tgt == ST_SHUTDOWN);
                ST_CLOSING:    ok = (tgt == ST_SHUTDOWN);
                ST_SHUTDOWN,
                ST_BROCKEN:    ok = (tgt == ST_LISTENING) || (tgt == ST_CONNECTING);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // -----------------------------------------------------------------------
    // Fixed-priority grant: a bit wins when no higher bit is requesting.
    // Grants are suppressed during reset and while the internal timeout
    // request owns the cycle; requesters simply keep valid high and wait.
    // -----------------------------------------------------------------------
    assign arb_en = ~core_rst & ~timeout_hit;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_grant
            assign grant[gi] = arb_en & bus.req_valid_i[gi]
                             & ~(|(bus.req_valid_i >> (gi + 1)));
        end
    endgenerate

    assign bus.req_ready_o = grant;

    always_comb begin
        grant_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (grant[i]) begin
                grant_idx = 3'(i);
            end
        end
    end

    assign target = state_t'(grant_idx + 3'd1);

    // -----------------------------------------------------------------------
    // Connect timeout
    // -----------------------------------------------------------------------
`ifdef UDT_STATE_ARB_TIMEOUT_EN
    logic [31:0] conn_cnt_reg;

    // Held at zero outside CONNECTING, so it is zero on the first cycle in
    // CONNECTING. Firing at CONNECT_TIMEOUT-1 makes the BROCKEN update land
    // on the edge where the count would reach CONNECT_TIMEOUT, i.e. exactly
    // CONNECT_TIMEOUT cycles after entry.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            conn_cnt_reg <= 32'd0;
        end else if (state_reg == ST_CONNECTING) begin
            conn_cnt_reg <= conn_cnt_reg + 32'd1;
        end else begin
            conn_cnt_reg <= 32'd0;
        end
    end

    assign timeout_hit = (state_reg == ST_CONNECTING)
                      && (conn_cnt_reg == CONNECT_TIMEOUT - 32'd1);
`else
    logic [31:0] unused_connect_timeout;
    assign unused_connect_timeout = CONNECT_TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next state / status
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        // Handshake retires the pending notification; a new legal
        // transition in the same cycle re-arms it below.
        state_valid_next = state_valid_reg & ~bus.state_ready_i;
        illegal_next     = 1'b0;
        illegal_cnt_next = illegal_cnt_reg;

        if (timeout_hit) begin
            state_next       = ST_BROCKEN;
            state_valid_next = 1'b1;
        end else if (|grant) begin
            if (is_legal(state_reg, target)) begin
                state_next       = target;
                state_valid_next = 1'b1;
            end else begin
                illegal_next = 1'b1;
                if (illegal_cnt_reg != 8'hFF) begin
                    illegal_cnt_next = illegal_cnt_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_reg       <= ST_INIT;
            state_valid_reg <= 1'b0;
            illegal_reg     <= 1'b0;
            illegal_cnt_reg <= 8'h00;
        end else begin
            state_reg       <= state_next;
            state_valid_reg <= state_valid_next;
            illegal_reg     <= illegal_next;
            illegal_cnt_reg <= illegal_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_code = 8'h00;
        unique case (state_reg)
            ST_LISTENING:  state_code = LISTENING;
            ST_CONNECTING: state_code = CONNECTING;
            ST_CONNECTED:  state_code = CONNECTED;
            ST_CLOSING:    state_code = CLOSING;
            ST_SHUTDOWN:   state_code = SHUTDOWN;
            ST_BROCKEN:    state_code = BROCKEN;
            default:       state_code = 8'h00;
        endcase
    end

    assign bus.udt_state_o   = {24'b0, state_code};
    assign bus.state_valid_o = state_valid_reg;
    assign bus.illegal_o     = illegal_reg;
    assign bus.illegal_cnt_o = illegal_cnt_reg;

endmodule

// File: tb/tb_udt_state_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udt_state_arbiter
//
// Drives directed scenarios followed by random request traffic into
// udt_state_arbiter and compares every cycle against a reference model of
// the socket state rules. Honours UDT_STATE_ARB_TIMEOUT_EN (timeout of 16).
// ---------------------------------------------------------------------------
module tb_udt_state_arbiter;

    localparam logic [31:0] TO = 32'd16;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;

    udt_state_arbiter_if bus();

    udt_state_arbiter #(
        .CONNECT_TIMEOUT (TO)
    ) dut (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .bus      (bus)
    );

    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0] m_state;
    logic       m_valid;
    logic       m_illegal;
    logic [7:0] m_cnt;
    int         m_conn;     // cycles spent in CONNECTING so far
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit legal(input logic [7:0] cur, input logic [7:0] tgt);
        if (tgt == 8'h20) return (cur != 8'h00) && (cur != 8'h20);
        case (cur)
            8'h00:        return (tgt == 8'h01) || (tgt == 8'h02);
            8'h01:        return tgt == 8'h02;
            8'h02:        return tgt == 8'h04;
            8'h04:        return (tgt == 8'h08) || (tgt == 8'h10);
            8'h08:        return tgt == 8'h10;
            8'h10, 8'h20: return (tgt == 8'h01) || (tgt == 8'h02);
            default:      return 1'b0;
        endcase
    endfunction

    function automatic bit timeout_now();
`ifdef UDT_STATE_ARB_TIMEOUT_EN
        return (m_state == 8'h02) && (m_conn == int'(TO) - 1);
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive inputs, check the combinational grant, then
    // check the registered outputs after the edge.
    task automatic step(input logic rst, input logic [5:0] v, input logic sr);
        logic [5:0] exp_rdy;
        logic [7:0] prev_state;
        bit         to;
        @(negedge core_clk);
        core_rst          = rst;
        bus.req_valid_i   = v;
        bus.state_ready_i = sr;
        #1;
        to      = timeout_now();
        exp_rdy = 6'b0;
        if (!rst && !to) begin
            for (int i = 5; i >= 0; i--) begin
                if (v[i]) begin
                    exp_rdy = 6'b1 << i;
                    break;
                end
            end
        end
        check("req_ready", {26'b0, bus.req_ready_o}, {26'b0, exp_rdy});

        @(posedge core_clk);
        #1;
        cyc++;
        prev_state = m_state;
        if (rst) begin
            m_state = 8'h00; m_valid = 1'b0; m_illegal = 1'b0; m_cnt = 8'h00;
        end else begin
            m_valid   = m_valid && !sr;
            m_illegal = 1'b0;
            if (to) begin
                m_state = 8'h20;
                m_valid = 1'b1;
            end else if (exp_rdy != 6'b0) begin
                if (legal(m_state, {2'b0, exp_rdy})) begin
                    m_state = {2'b0, exp_rdy};
                    m_valid = 1'b1;
                end else begin
                    m_illegal = 1'b1;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end
            end
        end
        if (m_state == 8'h02 && prev_state == 8'h02 && !rst) m_conn++;
        else m_conn = 0;

        check("udt_state", bus.udt_state_o, {24'b0, m_state});
        check("state_valid", {31'b0, bus.state_valid_o}, {31'b0, m_valid});
        check("illegal", {31'b0, bus.illegal_o}, {31'b0, m_illegal});
        check("illegal_cnt", {24'b0, bus.illegal_cnt_o}, {24'b0, m_cnt});
        $display("cyc %0d rst=%b req=%b sr=%b rdy=%b state=%h vld=%b ill=%b cnt=%0d",
                 cyc, rst, v, sr, bus.req_ready_o, bus.udt_state_o[7:0],
                 bus.state_valid_o, bus.illegal_o, bus.illegal_cnt_o);
    endtask

    initial begin
        logic [5:0] v;
        int         r;
        m_state = 8'h00; m_valid = 1'b0; m_illegal = 1'b0; m_cnt = 8'h00; m_conn = 0;
        bus.req_valid_i   = 6'b0;
        bus.state_ready_i = 1'b0;

        // Reset state; grants must stay low under reset even with requests
        step(1'b1, 6'b111111, 1'b0);
        step(1'b1, 6'b000000, 1'b0);

        // LISTENING, notification held until consumer accepts
        step(1'b0, 6'b000001, 1'b0);
        step(1'b0, 6'b000000, 1'b0);
        step(1'b0, 6'b000000, 1'b1);
        step(1'b0, 6'b000000, 1'b0);

        // Backpressured chain to CONNECTED, then a single handshake
        step(1'b0, 6'b000010, 1'b0);
        step(1'b0, 6'b000100, 1'b0);
        check("chain_state", bus.udt_state_o, 32'h04);
        step(1'b0, 6'b000000, 1'b1);

        // Priority: BROCKEN wins, then SHUTDOWN and CLOSING are illegal
        step(1'b0, 6'b111000, 1'b0);
        step(1'b0, 6'b011000, 1'b0);
        step(1'b0, 6'b001000, 1'b1);
        check("prio_cnt", {24'b0, bus.illegal_cnt_o}, 32'd2);
        step(1'b0, 6'b000000, 1'b0);

        // Illegal from INIT; same-cycle accept plus new transition
        step(1'b1, 6'b000000, 1'b0);
        step(1'b0, 6'b000100, 1'b0);
        step(1'b0, 6'b000000, 1'b0);
        step(1'b0, 6'b000001, 1'b0);
        step(1'b0, 6'b000010, 1'b1);
        step(1'b0, 6'b000010, 1'b0);   // request for current state

        // Connect timeout (or lack of it)
        step(1'b1, 6'b000000, 1'b0);
        step(1'b0, 6'b000010, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 6'b000000, 1'b1);
`ifdef UDT_STATE_ARB_TIMEOUT_EN
        check("timeout_state", bus.udt_state_o, 32'h20);
`else
        check("no_timeout_state", bus.udt_state_o, 32'h02);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, 6'b000000, 1'b1);

        // Saturating illegal counter, then reset mid-stream
        step(1'b1, 6'b000000, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b0, 6'b000100, 1'b0);
        check("sat_cnt", {24'b0, bus.illegal_cnt_o}, 32'hFF);
        step(1'b0, 6'b000001, 1'b0);
        step(1'b1, 6'b000100, 1'b0);
        step(1'b0, 6'b000000, 1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      v = 6'b0;
            else if (r < 8) v = 6'b1 << $urandom_range(0, 5);
            else            v = 6'($urandom);
            step(($urandom_range(0, 99) == 0), v, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udt_state_arbiter.md
# udt_state_arbiter

Central state sequencer for one UDT socket. It arbitrates the state-change requests raised by the server/client handshake managers and the external broken-link detector, and checks each request against the legal UDT transition graph. It holds the single authoritative connection state and publishes every change on a valid/ready status channel. It sits between the socket manager instances and the status consumer, replacing ad-hoc per-channel state updates.

## Interface
Parameters:
- LISTENING, default 8'b0000_0001, state code
- CONNECTING, default 8'b0000_0010, state code
- CONNECTED, default 8'b0000_0100, state code
- CLOSING, default 8'b0000_1000, state code
- SHUTDOWN, default 8'b0001_0000, state code
- BROCKEN, default 8'b0010_0000, state code
- CONNECT_TIMEOUT, default 32'd1_000_000, core_clk cycles allowed in CONNECTING (only used with the timeout feature)

Ports:
- core_clk  in  1  core clock; the only clock
- core_rst  in  1  reset, synchronous, active-high
- req_valid_i  in  6  request per target state; bit 0..5 = LISTENING, CONNECTING, CONNECTED, CLOSING, SHUTDOWN, BROCKEN
- req_ready_o  out  6  grant per request bit
- udt_state_o  out  32  {24'b0, current state code}
- state_valid_o  out  1  state-change notification pending
- state_ready_i  in  1  consumer accepts the notification
- illegal_o  out  1  one-cycle pulse: an accepted request was illegal
- illegal_cnt_o  out  8  saturating count of illegal requests

## Operation
- Internal state register, reset value INIT = 8'h00.
- Arbitration: fixed priority BROCKEN > SHUTDOWN > CLOSING > CONNECTED > CONNECTING > LISTENING.
  - req_ready_o is combinational and one-hot-or-zero; it is asserted only on the highest-priority valid bit.
  - A transfer is valid & ready. At most one transfer per cycle. Lower-priority requesters hold valid and wait.
- Legal transitions:
  - INIT -> LISTENING or CONNECTING
  - LISTENING -> CONNECTING
  - CONNECTING -> CONNECTED
  - CONNECTED -> CLOSING or SHUTDOWN
  - CLOSING -> SHUTDOWN
  - SHUTDOWN or BROCKEN -> LISTENING or CONNECTING
  - any state except INIT and BROCKEN -> BROCKEN
- Illegal request (including a request for the current state):
  - still accepted (ready high), so the requester never deadlocks
  - state is unchanged
  - illegal_o pulses and illegal_cnt_o increments, saturating at 8'hFF
- Status channel:
  - A legal transition sets state_valid_o, which holds until state_valid_o & state_ready_i.
  - If another legal transition occurs while notification is pending, udt_state_o shows the newest state and state_valid_o stays high. Only the latest state is reported; transitions are never blocked by backpressure.
  - Same-cycle accept plus new transition: state_valid_o stays high with the new state.

## Timing
- Reset values: udt_state_o 0, state_valid_o 0, illegal_o 0, illegal_cnt_o 0. req_ready_o is 0 while core_rst is high.
- Request accepted in cycle N: udt_state_o and state_valid_o (or illegal_o) update at the edge ending cycle N, i.e. 1-cycle latency.
- req_ready_o has zero-cycle latency from req_valid_i. No combinational path from state_ready_i to req_ready_o.
- Reset asserted mid-operation: all registers return to reset values on that edge, and a pending notification is discarded.

## Configuration
- UDT_STATE_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to CONNECTING and increments each cycle while in CONNECTING.
  - When it reaches CONNECT_TIMEOUT, an internal BROCKEN request is raised at top priority. That cycle, all req_ready_o are 0 and the state goes to BROCKEN.
  - The counter stops outside CONNECTING.
- Not defined: no counter logic; CONNECTING is left only by external requests.

## Test plan
- Reset then req_valid_i=6'b000001 for 1 cycle -> next cycle udt_state_o=32'h01, state_valid_o=1; it holds until state_ready_i=1.
- In CONNECTED, assert req_valid_i=6'b111000 -> cycle 1 grants BROCKEN only (req_ready_o=6'b100000), state=32'h20; CLOSING and SHUTDOWN then fail as illegal, illegal_cnt_o=2.
- From INIT, req_valid_i=6'b000100 -> ready=6'b000100, illegal_o pulses 1 cycle, udt_state_o stays 0, state_valid_o stays 0.
- state_ready_i=0 while driving LISTENING -> CONNECTING -> CONNECTED -> udt_state_o=32'h04, state_valid_o=1; one handshake clears it.
- 256 illegal requests -> illegal_cnt_o saturates at 8'hFF; core_rst=1 mid-stream -> all outputs 0 on the next edge.
- With UDT_STATE_ARB_TIMEOUT_EN and CONNECT_TIMEOUT=16: enter CONNECTING and hold no requests -> state becomes 32'h20 exactly 16 cycles after entry. Without the macro, state stays 32'h02.
